uart_rx_cfg: RTL and testbench

Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver. It adds configurable data width, parity and stop bits, oversampled majority-vote sampling, an input synchroniser, framing and parity error reporting, and a valid/ready output with overrun detection. It sits between the board-level RX pin and any stream consumer, such as a command parser or a FIFO.

---
 rtl/uart_rx_cfg.sv | 155 +++++++++++++++
 tb/tb_uart_rx_cfg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled, configurable UART receiver with valid/ready output and overrun detection
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 rx_busy
);
  localparam int DIV_RAW  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW       = $clog2(TICK_DIV + 1);
  localparam int M        = OVERSAMPLE / 2;
  localparam int BW       = $clog2(OVERSAMPLE);
  localparam int NW       = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0) begin : g_bad_oversample
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rxs;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [BW-1:0]        bc;
  logic [NW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 armed;
  logic                 s0;
  logic                 s1;
  logic                 maj;
  logic [DATA_BITS-1:0] sh;
  logic                 pe;
  logic                 fe;
  logic                 start_det;
  logic                 dec;
  logic                 push;

  assign rxs       = sync[1];
  assign tick      = div_cnt == DW'(TICK_DIV - 1);
  assign maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign start_det = state == IDLE && armed && !rxs;
  assign dec       = state != IDLE && tick && bc == BW'(M + 1);
  assign push      = dec && state == STOP && stop_cnt == 1'(STOP_BITS - 1);

  // two-flop synchroniser, idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], rx};

  // oversample tick divider, re-phased on every start detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= (start_det || tick) ? '0 : div_cnt + DW'(1);

  // frame state machine: 3-sample majority per bit, decision on the last sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      rx_busy  <= 1'b0;
      bc       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      sh       <= '0;
      pe       <= 1'b0;
      fe       <= 1'b0;
    end else if (state == IDLE) begin
      if (start_det) begin
        state    <= START;
        armed    <= 1'b0;
        rx_busy  <= 1'b1;
        bc       <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        pe       <= 1'b0;
        fe       <= 1'b0;
      end else if (rxs) begin
        armed <= 1'b1;
      end
    end else if (tick) begin
      bc <= bc == BW'(OVERSAMPLE - 1) ? '0 : bc + BW'(1);
      if (bc == BW'(M - 1)) s0 <= rxs;
      if (bc == BW'(M)) s1 <= rxs;
      if (dec)
        case (state)
          START: begin
            state   <= maj ? IDLE : DATA;
            rx_busy <= !maj;
          end
          DATA: begin
            sh      <= {maj, sh[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + NW'(1);
            if (bit_cnt == NW'(DATA_BITS - 1)) state <= PARITY != 0 ? PAR : STOP;
          end
          PAR: begin
            pe    <= ((^sh) ^ maj) != (PARITY == 1);
            state <= STOP;
          end
          default: begin
            fe       <= fe | !maj;
            stop_cnt <= 1'b1;
            if (push) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
        endcase
    end

  // output register: accept a push when empty or draining, otherwise drop and flag overrun
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_valid      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= push && m_valid && !m_ready;
      if (push && (!m_valid || m_ready)) begin
        m_data       <= sh;
        m_parity_err <= pe;
        m_frame_err  <= fe | !maj;
        m_valid      <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized and directed frames for a 7E2 receiver checked against a word-level model
module tb_uart_rx_cfg;
  localparam int DB = 7;
  localparam int BT = 16;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          m_ready = 1'b1;
  logic [DB-1:0] m_data;
  logic          m_parity_err;
  logic          m_frame_err;
  logic          m_valid;
  logic          overrun;
  logic          rx_busy;

  word_t q[$];
  int    exp_ovr = 0;
  int    ovr_total = 0;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_start = 0;
  int    rise_cyc = 0;
  int    busy_rise_cyc = 0;
  bit    busy_seen = 1'b0;
  logic  prev_valid = 1'b0;
  logic  prev_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
    .DATA_BITS(DB), .PARITY(2), .STOP_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .m_data(m_data),
    .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
    .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun), .rx_busy(rx_busy)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // every presented word must be the model's head; every overrun must be one the model predicted
  always @(negedge clk)
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (m_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid actual=%0h required=no word", m_data);
        end else begin
          chk("data", m_data, q[0].d);
          chk("parity_err", m_parity_err, q[0].pe);
          chk("frame_err", m_frame_err, q[0].fe);
        end
        if (!prev_valid) begin
          chk("busy_falls_with_valid", {prev_busy, rx_busy}, 2'b10);
          rise_cyc = cyc;
        end
        if (m_ready && q.size() > 0) void'(q.pop_front());
      end
      if (overrun) begin
        ovr_total++;
        checks++;
        if (exp_ovr == 0) begin
          errors++;
          $display("FAIL unexpected_overrun actual=1 required=0");
        end else exp_ovr--;
      end
      if (rx_busy && !prev_busy) busy_rise_cyc = cyc;
      if (rx_busy) busy_seen = 1'b1;
      prev_valid = m_valid;
      prev_busy  = rx_busy;
    end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick_n(n);
  endtask

  // one 11-bit frame: start, 7 data LSB first, even parity, two stops
  task automatic send(input logic [DB-1:0] d, input bit bad_par, input bit bad_s1, input bit bad_s2,
                      input int spike_bit, input int rst_bit, input bit coincide);
    logic [10:0] f;
    f = {~bad_s2, ~bad_s1, (^d) ^ bad_par, d, 1'b0};
    last_start = cyc;
    if (!m_ready && q.size() > 0 && !coincide) exp_ovr++;
    else q.push_back('{d: d, pe: bad_par, fe: bad_s1 | bad_s2});
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < BT; j++) begin
        if (i == rst_bit && j == 0) begin
          rst_n = 1'b0;
          #2;
          chk("rst_data", m_data, 0);
          chk("rst_valid", m_valid, 0);
          chk("rst_busy", rx_busy, 0);
          chk("rst_errs", {m_parity_err, m_frame_err, overrun}, 0);
          q.delete();
          exp_ovr = 0;
          rx = 1'b1;
          tick_n(3);
          rst_n = 1'b1;
          return;
        end
        rx = (i == spike_bit && j == 9) ? ~f[i] : f[i];
        if (coincide && i == 10) m_ready = (j == 12);
        tick_n(1);
      end
  endtask

  initial begin
    tick_n(3);
    chk("reset_data", m_data, 0);
    chk("reset_valid", m_valid, 0);
    chk("reset_flags", {m_parity_err, m_frame_err, overrun, rx_busy}, 0);
    rst_n = 1'b1;
    idle(5);

    send(7'h25, 0, 0, 0, -1, -1, 0);
    chk("busy_rise_latency", busy_rise_cyc - last_start, 3);
    chk("valid_latency", rise_cyc - last_start, 173);
    idle(5);

    m_ready = 1'b0;
    send(7'h41, 0, 0, 0, -1, -1, 0);
    idle(3);
    chk("par_ok_data", m_data, 7'h41);
    chk("par_ok_err", m_parity_err, 0);
    m_ready = 1'b1;
    idle(3);
    m_ready = 1'b0;
    send(7'h41, 1, 0, 0, -1, -1, 0);
    idle(3);
    chk("par_bad_data", m_data, 7'h41);
    chk("par_bad_err", m_parity_err, 1);
    m_ready = 1'b1;
    idle(3);

    send(7'h2B, 0, 0, 1, -1, -1, 0);
    rx = 1'b0;
    tick_n(30 * BT);
    chk("break_no_valid", m_valid, 0);
    chk("break_not_busy", rx_busy, 0);
    idle(20);
    send(7'h15, 0, 0, 0, -1, -1, 0);
    idle(5);

    busy_seen = 1'b0;
    rx = 1'b0;
    tick_n(5);
    idle(40);
    chk("glitch_busy_pulse", busy_seen, 1);
    chk("glitch_no_valid", m_valid, 0);
    send(7'h00, 0, 0, 0, 4, -1, 0);
    idle(5);

    m_ready = 1'b0;
    send(7'h11, 0, 0, 0, -1, -1, 0);
    idle(4);
    send(7'h22, 0, 0, 0, -1, -1, 0);
    idle(4);
    chk("bp_data_held", m_data, 7'h11);
    chk("bp_valid", m_valid, 1);
    chk("bp_overrun_once", ovr_total, 1);
    chk("bp_overrun_seen", exp_ovr, 0);
    m_ready = 1'b1;
    tick_n(1);
    chk("bp_drain_valid", m_valid, 0);
    idle(4);

    m_ready = 1'b0;
    send(7'h33, 0, 0, 0, -1, -1, 0);
    idle(2);
    send(7'h44, 0, 0, 0, -1, -1, 1);
    idle(2);
    chk("co_new_word", m_data, 7'h44);
    chk("co_valid", m_valid, 1);
    chk("co_no_overrun", ovr_total, 1);
    m_ready = 1'b1;
    idle(4);

    send(7'h5A, 0, 0, 0, -1, 5, 0);
    idle(10);
    chk("rst_no_word", m_valid, 0);
    send(7'h3C, 0, 0, 0, -1, -1, 0);
    idle(5);

    for (int k = 0; k < 40; k++) begin
      m_ready = $urandom_range(0, 3) != 0;
      send(7'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 0, -1, -1, 0);
      idle($urandom_range(0, 12));
    end
    m_ready = 1'b1;
    idle(40);
    chk("final_queue_empty", q.size(), 0);
    chk("final_overruns_seen", exp_ovr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
